// File: rtl/dual_ram_init_if.sv
// Bus bundle for dual_ram_init: control, both user ports and status outputs.
interface dual_ram_init_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 9
) ();
    logic              init_req;
    logic              busy;
    logic              collision;
    logic              wr_en_0;
    logic              rd_en_0;
    logic [ADDR_W-1:0] addr_0;
    logic [WIDTH-1:0]  data_0_in;
    logic [WIDTH-1:0]  data_0_out;
    logic              rd_valid_0;
    logic              wr_en_1;
    logic              rd_en_1;
    logic [ADDR_W-1:0] addr_1;
    logic [WIDTH-1:0]  data_1_in;
    logic [WIDTH-1:0]  data_1_out;
    logic              rd_valid_1;

    modport master (
        output init_req, wr_en_0, rd_en_0, addr_0, data_0_in,
        output wr_en_1, rd_en_1, addr_1, data_1_in,
        input  busy, collision, data_0_out, rd_valid_0, data_1_out, rd_valid_1
    );

    modport slave (
        input  init_req, wr_en_0, rd_en_0, addr_0, data_0_in,
        input  wr_en_1, rd_en_1, addr_1, data_1_in,
        output busy, collision, data_0_out, rd_valid_0, data_1_out, rd_valid_1
    );
endinterface

// File: rtl/dual_ram_init.sv
// True dual-port RAM with a hardware init sweep, per-port read-valid, selectable
// read-during-write behaviour and an optional output register stage.
module dual_ram_init #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_W     = 9,
    parameter logic [63:0] INIT_VALUE = 64'h0000_0000_0001_0000,
    parameter bit          RDW_MODE   = 1'b0,
    parameter bit          OUT_REG    = 1'b0
) (
    input logic            clk,
    input logic            rst,
    dual_ram_init_if.slave bus
);
    localparam logic [WIDTH-1:0]  InitWord = WIDTH'(INIT_VALUE);
    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-2:0] LastK    = (ADDR_W - 1)'(DEPTH / 2 - 1);

    typedef enum logic {StInit, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-2:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              collision_q, collision_d;
    logic [1:0]        s1_valid_q, s1_valid_d;
    logic [1:0]        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  s1_data_q [2];
    logic [WIDTH-1:0]  s1_data_d [2];
    logic [WIDTH-1:0]  out_data_q [2];
    logic [WIDTH-1:0]  out_data_d [2];

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready, same_addr, we_0, we_1;
    logic [ADDR_W-1:0] addr [2];
    logic [WIDTH-1:0]  wdata [2];
    logic [WIDTH-1:0]  rd_word [2];
    logic [1:0]        wr_en, rd_en, in_range, re;

    // Port decode: range check, read-during-write selection and write arbitration.
    always_comb begin
        addr[0]  = bus.addr_0;
        addr[1]  = bus.addr_1;
        wdata[0] = bus.data_0_in;
        wdata[1] = bus.data_1_in;
        wr_en    = {bus.wr_en_1, bus.wr_en_0};
        rd_en    = {bus.rd_en_1, bus.rd_en_0};
        ready    = (state_q == StReady);
        in_range = '0;
        re       = '0;
        for (int p = 0; p < 2; p++) begin
            in_range[p] = ({1'b0, addr[p]} < DepthW);
            re[p]       = ready && rd_en[p];
            if (!in_range[p]) begin
                rd_word[p] = '0;
            end else if (RDW_MODE && wr_en[p]) begin
                rd_word[p] = wdata[p];
            end else begin
                rd_word[p] = mem[addr[p]];
            end
        end
        same_addr   = (addr[0] == addr[1]);
        we_0        = ready && wr_en[0] && in_range[0];
        we_1        = ready && wr_en[1] && in_range[1] && !(we_0 && same_addr);
        collision_d = we_0 && wr_en[1] && same_addr;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastK) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                if (bus.init_req) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == StInit);

        // Reads already captured keep flowing through the pipe even once a sweep starts.
        s1_valid_d = re;
        for (int p = 0; p < 2; p++) begin
            s1_data_d[p] = rd_word[p];
            if (OUT_REG) begin
                out_valid_d[p] = s1_valid_q[p];
                out_data_d[p]  = s1_valid_q[p] ? s1_data_q[p] : out_data_q[p];
            end else begin
                out_valid_d[p] = re[p];
                out_data_d[p]  = re[p] ? rd_word[p] : out_data_q[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            collision_q <= 1'b0;
            s1_valid_q  <= '0;
            out_valid_q <= '0;
            for (int p = 0; p < 2; p++) begin
                s1_data_q[p]  <= '0;
                out_data_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            for (int p = 0; p < 2; p++) begin
                s1_data_q[p]  <= s1_data_d[p];
                out_data_q[p] <= out_data_d[p];
            end
        end
    end

    // Sweep fills an even/odd word pair per cycle; storage itself has no reset.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[{cnt_q, 1'b0}] <= InitWord;
            mem[{cnt_q, 1'b1}] <= InitWord;
        end else begin
            if (we_0) mem[addr[0]] <= wdata[0];
            if (we_1) mem[addr[1]] <= wdata[1];
        end
    end

    assign bus.busy       = busy_q;
    assign bus.collision  = collision_q;
    assign bus.data_0_out = out_data_q[0];
    assign bus.rd_valid_0 = out_valid_q[0];
    assign bus.data_1_out = out_data_q[1];
    assign bus.rd_valid_1 = out_valid_q[1];
endmodule
